// File: rtl/serial_frame_tx_pkg.sv
// ============================================================================
// Module      : serial_frame_tx_pkg
// Description : Shared types and constants for the single-wire serial link
//               (framer state encoding, line levels, counter sizing helper).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_frame_tx_pkg;

  // Framer states, 3-bit encoding shared with the receiver side.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Line levels of the link.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_frame_tx_bit_timer.sv
// ============================================================================
// Module      : bit_timer
// Description : Bit-period timer for the serial link. Counts 0..CLKS_PER_BIT-1
//               and raises tick_o on the last clock of every bit period.
//               Holding clear_i keeps the count at 0 so a bit period starts
//               exactly on the first clock after clear_i drops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_timer
  import serial_frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear_i,
  output logic tick_o
);

  // Count width is at least one bit so CLKS_PER_BIT=1 still builds.
  localparam int TW = (clog2(CLKS_PER_BIT) > 0) ? clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Last clock of the current bit period.
  assign tick_o = (count_q == LAST);

  // Next count: wrap on the last clock, hold at zero while cleared.
  always_comb begin
    count_d = count_q + TW'(1);
    if (clear_i || tick_o) begin
      count_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_frame_tx.sv
// ============================================================================
// Module      : serial_frame_tx
// Description : Parallel-in, serial-out framed transmitter. Sends start bit,
//               WIDTH data bits LSB first, optional even parity, stop bit,
//               each held for CLKS_PER_BIT clocks. TXD and DONE are registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD,
  output logic             READY,
  output logic             TXD,
  output logic             BUSY,
  output logic             DONE
);

  localparam int BW = clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] shreg_q,  shreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic             parity_q, parity_d;
  logic             txd_q,    txd_d;
  logic             done_q,   done_d;
  logic             bit_tick;

  // Timer is held clear while idle so the start bit gets a full period.
  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clear_i (state_q == IDLE),
    .tick_o  (bit_tick)
  );

  assign READY = (state_q == IDLE);
  assign BUSY  = ~READY;
  assign TXD   = txd_q;
  assign DONE  = done_q;

  // Next-state logic; txd_d is the line level for the coming bit period, so
  // TXD changes on the same edge as the state.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    parity_d = parity_q;
    txd_d    = txd_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        txd_d = LINE_IDLE;
        if (LOAD) begin
          state_d  = START;
          shreg_d  = DIN;
          parity_d = ^DIN;
          bitcnt_d = '0;
          txd_d    = START_LVL;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          txd_d   = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bitcnt_q == LAST_BIT) begin
            if (PARITY_EN) begin
              state_d = PARITY;
              txd_d   = parity_q;
            end else begin
              state_d = STOP;
              txd_d   = STOP_LVL;
            end
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
            shreg_d  = shreg_q >> 1;
            txd_d    = shreg_d[0];
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          txd_d   = STOP_LVL;
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
          txd_d   = LINE_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = LINE_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame without DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      parity_q <= 1'b0;
      txd_q    <= LINE_IDLE;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      parity_q <= parity_d;
      txd_q    <= txd_d;
      done_q   <= done_d;
    end
  end

endmodule

`default_nettype wire
